reg_exec_stage: RTL and testbench

- Execute/write-back stage directly downstream of the 16x24-bit register file.
- Accepts one decoded instruction via valid/ready and drives the register file read addresses.
- Captures both operands, computes the result (single-cycle ALU ops or multi-cycle 3-bit-field rotation), then issues exactly one write-back strobe (we/dst/data) into the register file.

---
 rtl/exec_pkg.sv | 27 ++
 rtl/exec_alu.sv | 35 +++
 rtl/reg_exec_stage.sv | 144 ++++++++++++++
 tb/tb_reg_exec_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute/write-back stage: default widths,
// opcode encodings and the FSM state encoding.
package exec_pkg;

  localparam int EXEC_DW = 24;  // datapath width, matches register file word
  localparam int EXEC_AW = 4;   // 16 registers
  localparam int EXEC_FW = 3;   // packed field width used by ROTF

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_MOV  = 4'd6;
  localparam logic [3:0] OP_ROTF = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU for the single-cycle opcodes. ROTF is iterated in the
// stage datapath; here it simply passes operand A (the k=0 result).
module exec_alu
  import exec_pkg::*;
#(
  parameter int DW = EXEC_DW
) (
  input  logic [3:0]    op,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  input  logic [4:0]    imm,
  output logic [DW-1:0] result,
  output logic          illegal
);

  // Opcode decode; shifts by imm >= DW naturally produce zero.
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (op)
      OP_NOP:  result = '0;
      OP_ADD:  result = opa + opb;
      OP_SUB:  result = opa - opb;
      OP_AND:  result = opa & opb;
      OP_OR:   result = opa | opb;
      OP_XOR:  result = opa ^ opb;
      OP_MOV:  result = opa;
      OP_ROTF: result = opa;
      OP_SHL:  result = opa << imm;
      OP_SHR:  result = opa >> imm;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_exec_stage.sv
// Execute/write-back stage behind the 16-entry register file.
// Handshake: an instruction is taken on a rising edge where instr_valid and
// instr_ready are both high; instr_ready is high only in IDLE, so the stage
// holds at most one instruction and ignores instr_valid while busy.
// Flow: IDLE -> READ (operands sampled) -> EXEC (1 cycle, or k cycles for
// ROTF) -> WB (single write-back strobe plus done/err pulse) -> IDLE.
module reg_exec_stage
  import exec_pkg::*;
#(
  parameter int DW = EXEC_DW,
  parameter int AW = EXEC_AW,
  parameter int FW = EXEC_FW   // DW must be a multiple of FW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [3:0]    instr_op,
  input  logic [AW-1:0] instr_dst,
  input  logic [AW-1:0] instr_src0,
  input  logic [AW-1:0] instr_src1,
  input  logic [4:0]    instr_imm,
  output logic [AW-1:0] rf_src0,
  output logic [AW-1:0] rf_src1,
  input  logic [DW-1:0] rf_outa,
  input  logic [DW-1:0] rf_outb,
  output logic          wb_we,
  output logic [AW-1:0] wb_dst,
  output logic [DW-1:0] wb_data,
  output logic          done,
  output logic          err
);

  state_t        state;
  logic [3:0]    op_q;
  logic [AW-1:0] dst_q;
  logic [AW-1:0] src0_q;
  logic [AW-1:0] src1_q;
  logic [4:0]    imm_q;
  logic [DW-1:0] opa;
  logic [DW-1:0] opb;
  logic [DW-1:0] acc;
  logic [2:0]    cnt;

  logic [DW-1:0] alu_result;
  logic          alu_illegal;
  logic [DW-1:0] acc_rot;
  logic [DW-1:0] exec_data;
  logic          exec_last;

  assign rf_src0 = src0_q;
  assign rf_src1 = src1_q;

  // One ROTF step: move the top field down to the bottom.
  assign acc_rot = {acc[DW-FW-1:0], acc[DW-1:DW-FW]};

  exec_alu #(.DW(DW)) u_alu (
    .op      (op_q),
    .opa     (opa),
    .opb     (opb),
    .imm     (imm_q),
    .result  (alu_result),
    .illegal (alu_illegal)
  );

  // Result and completion of the current EXEC cycle. ROTF finishes on the
  // cycle its remaining step count is 0 (k=0) or 1 (last rotation).
  always_comb begin
    exec_data = alu_result;
    exec_last = 1'b1;
    if (op_q == OP_ROTF) begin
      exec_data = (cnt == 3'd0) ? acc : acc_rot;
      exec_last = (cnt <= 3'd1);
    end
  end

  // Stage FSM with registered handshake and write-back outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      instr_ready <= 1'b1;
      op_q        <= '0;
      dst_q       <= '0;
      src0_q      <= '0;
      src1_q      <= '0;
      imm_q       <= '0;
      opa         <= '0;
      opb         <= '0;
      acc         <= '0;
      cnt         <= '0;
      wb_we       <= 1'b0;
      wb_dst      <= '0;
      wb_data     <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            op_q        <= instr_op;
            dst_q       <= instr_dst;
            src0_q      <= instr_src0;
            src1_q      <= instr_src1;
            imm_q       <= instr_imm;
            instr_ready <= 1'b0;
            state       <= ST_READ;
          end
        end
        ST_READ: begin
          // Operands are frozen here, so a write-back to a source register
          // cannot disturb the instruction that produced it.
          opa   <= rf_outa;
          opb   <= rf_outb;
          acc   <= rf_outa;
          cnt   <= imm_q[2:0];
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op_q == OP_ROTF && cnt != 3'd0) begin
            acc <= acc_rot;
            cnt <= cnt - 3'd1;
          end
          if (exec_last) begin
            wb_we   <= !alu_illegal && (op_q != OP_NOP);
            wb_dst  <= dst_q;
            wb_data <= exec_data;
            done    <= 1'b1;
            err     <= alu_illegal;
            state   <= ST_WB;
          end
        end
        ST_WB: begin
          wb_we       <= 1'b0;
          done        <= 1'b0;
          err         <= 1'b0;
          instr_ready <= 1'b1;
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_exec_stage.sv
// Directed bench for reg_exec_stage with a behavioural 16x24 register file.
module tb_reg_exec_stage;

  localparam int DW = 24;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_dst;
  logic [AW-1:0] instr_src0;
  logic [AW-1:0] instr_src1;
  logic [4:0]    instr_imm;
  logic [AW-1:0] rf_src0;
  logic [AW-1:0] rf_src1;
  logic [DW-1:0] rf_outa;
  logic [DW-1:0] rf_outb;
  logic          wb_we;
  logic [AW-1:0] wb_dst;
  logic [DW-1:0] wb_data;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;
  int we_count = 0;
  int accepts  = 0;

  logic [DW-1:0] rf [16];

  reg_exec_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_op    (instr_op),
    .instr_dst   (instr_dst),
    .instr_src0  (instr_src0),
    .instr_src1  (instr_src1),
    .instr_imm   (instr_imm),
    .rf_src0     (rf_src0),
    .rf_src1     (rf_src1),
    .rf_outa     (rf_outa),
    .rf_outb     (rf_outb),
    .wb_we       (wb_we),
    .wb_dst      (wb_dst),
    .wb_data     (wb_data),
    .done        (done),
    .err         (err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // register file model: preset contents on reset, written by wb strobe
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
      rf[0]  <= 24'h000000;
      rf[1]  <= 24'h000001;
      rf[2]  <= 24'h900000;
      rf[5]  <= 24'h800001;
      rf[7]  <= 24'h1F58D1;
      rf[8]  <= 24'hF0F0F0;
      rf[9]  <= 24'h0FF00F;
      rf[12] <= 24'h000001;
      rf[15] <= 24'hFFFFFF;
    end else if (wb_we) begin
      rf[wb_dst] <= wb_data;
    end
  end
  assign rf_outa = rf[rf_src0];
  assign rf_outb = rf[rf_src1];

  // event counters
  always @(posedge clk) begin
    if (wb_we) we_count <= we_count + 1;
    if (rst_n && instr_valid && instr_ready) accepts <= accepts + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one instruction at a negedge, then measure cycles until done.
  task automatic run_instr(input string tag, input logic [3:0] op, input logic [3:0] dst,
                           input logic [3:0] s0, input logic [3:0] s1, input logic [4:0] imm,
                           input logic [23:0] exp_data, input bit exp_we, input bit exp_err,
                           input int exp_lat);
    int guard;
    int lat;
    int we0;
    guard = 0;
    while (!instr_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check({tag, " ready_in"}, instr_ready, 1);
    instr_op = op; instr_dst = dst; instr_src0 = s0; instr_src1 = s1; instr_imm = imm;
    instr_valid = 1'b1;
    we0 = we_count;
    @(negedge clk);
    instr_valid = 1'b0;
    lat = 1;
    while (!done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " done"}, done, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " wb_we"}, wb_we, exp_we);
    check({tag, " err"}, err, exp_err);
    if (exp_we) begin
      check({tag, " wb_dst"}, wb_dst, dst);
      check({tag, " wb_data"}, wb_data, exp_data);
    end
    @(negedge clk);
    check({tag, " ready_after"}, instr_ready, 1);
    check({tag, " done_pulse"}, done, 0);
    check({tag, " we_count"}, we_count - we0, exp_we ? 1 : 0);
  endtask

  initial begin
    int acc0;
    int we0;
    int guard;
    rst_n = 1'b0;
    instr_valid = 1'b0;
    instr_op = '0; instr_dst = '0; instr_src0 = '0; instr_src1 = '0; instr_imm = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // reset state
    check("rst ready", instr_ready, 1);
    check("rst wb_we", wb_we, 0);
    check("rst done", done, 0);
    check("rst err", err, 0);
    check("rst wb_dst", wb_dst, 0);
    check("rst wb_data", wb_data, 0);
    check("rst rf_src0", rf_src0, 0);
    check("rst rf_src1", rf_src1, 0);

    // single-cycle ops: 3 cycles from accept to write-back
    run_instr("add_wrap", 4'd1, 4'd3, 4'd12, 4'd15, 5'd0, 24'h000000, 1, 0, 3);
    run_instr("sub_wrap", 4'd2, 4'd6, 4'd0, 4'd1, 5'd0, 24'hFFFFFF, 1, 0, 3);
    run_instr("shr4", 4'd9, 4'd10, 4'd2, 4'd0, 5'd4, 24'h090000, 1, 0, 3);
    run_instr("shl24", 4'd8, 4'd11, 4'd7, 4'd0, 5'd24, 24'h000000, 1, 0, 3);
    run_instr("shr31", 4'd9, 4'd11, 4'd15, 4'd0, 5'd31, 24'h000000, 1, 0, 3);
    run_instr("and", 4'd3, 4'd13, 4'd8, 4'd9, 5'd0, 24'h00F000, 1, 0, 3);
    run_instr("or", 4'd4, 4'd13, 4'd8, 4'd9, 5'd0, 24'hFFF0FF, 1, 0, 3);
    run_instr("xor", 4'd5, 4'd13, 4'd8, 4'd9, 5'd0, 24'hFF00FF, 1, 0, 3);
    run_instr("mov", 4'd6, 4'd14, 4'd7, 4'd0, 5'd0, 24'h1F58D1, 1, 0, 3);

    // ROTF: k=1 one 3-bit rotation, imm=8 -> k=0 pass-through,
    // k=7 = rotate left 21 bits = rotate right 3 bits -> 0x23EB1A, 6 extra cycles
    run_instr("rotf_k1", 4'd7, 4'd10, 4'd7, 4'd0, 5'd1, 24'hFAC688, 1, 0, 3);
    run_instr("rotf_k0", 4'd7, 4'd10, 4'd7, 4'd0, 5'd8, 24'h1F58D1, 1, 0, 3);
    run_instr("rotf_k7", 4'd7, 4'd10, 4'd7, 4'd0, 5'd7, 24'h23EB1A, 1, 0, 9);

    // NOP and illegal opcode: done only / done+err, never a write
    run_instr("nop", 4'd0, 4'd4, 4'd7, 4'd0, 5'd0, 24'h000000, 0, 0, 3);
    run_instr("illegal12", 4'd12, 4'd4, 4'd7, 4'd0, 5'd0, 24'h000000, 0, 1, 3);

    // dst equals both sources: 0x800001 + 0x800001 -> 0x000002, then read back
    run_instr("add_self", 4'd1, 4'd5, 4'd5, 4'd5, 5'd0, 24'h000002, 1, 0, 3);
    run_instr("mov_self", 4'd6, 4'd14, 4'd5, 4'd0, 5'd0, 24'h000002, 1, 0, 3);

    // instr_valid held high: one accept per IDLE visit, mid-op field changes ignored
    acc0 = accepts;
    instr_op = 4'd1; instr_dst = 4'd3; instr_src0 = 4'd8; instr_src1 = 4'd9; instr_imm = '0;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_op = 4'd5; instr_dst = 4'd13;
    check("hold ready_read", instr_ready, 0);
    @(negedge clk);
    check("hold ready_exec", instr_ready, 0);
    @(negedge clk);
    check("hold ready_wb", instr_ready, 0);
    check("hold done", done, 1);
    check("hold wb_dst", wb_dst, 3);
    check("hold wb_data", wb_data, 24'h00E0FF);
    check("hold accepts1", accepts - acc0, 1);
    @(negedge clk);
    check("hold ready_idle", instr_ready, 1);
    @(negedge clk);
    instr_valid = 1'b0;
    check("hold accepts2", accepts - acc0, 2);
    guard = 0;
    while (!done && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("hold2 done", done, 1);
    check("hold2 wb_dst", wb_dst, 13);
    check("hold2 wb_data", wb_data, 24'hFF00FF);
    @(negedge clk);

    // reset during ROTF EXEC (k=5): no write, back to IDLE
    we0 = we_count;
    instr_op = 4'd7; instr_dst = 4'd11; instr_src0 = 4'd7; instr_src1 = 4'd0; instr_imm = 5'd5;
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstmid ready", instr_ready, 1);
    check("rstmid wb_we", wb_we, 0);
    check("rstmid done", done, 0);
    check("rstmid wb_data", wb_data, 0);
    check("rstmid rf_src0", rf_src0, 0);
    repeat (10) @(negedge clk);
    check("rstmid no_write", we_count - we0, 0);
    run_instr("mov_after_rst", 4'd6, 4'd14, 4'd7, 4'd0, 5'd0, 24'h1F58D1, 1, 0, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
